// File: rtl/rotate_right_restorer.sv
// -----------------------------------------------------------------------------
// rotate_right_restorer
//
// Undoes a left rotation. A word that was left-rotated by in_amt is captured,
// then rotated right one bit per enabled cycle until the original word is back.
// The restored word is then offered on an output valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   async_rst  asynchronous, active-high reset
//   en         rotate enable; 0 freezes rotation while rotating
//   in_valid   source offers in_data / in_amt
//   in_ready   block can accept a word (high only when idle)
//   in_data    left-rotated word to restore
//   in_amt     number of right-rotate steps, 0..DW-1
//   out_valid  out_data holds the restored word
//   out_ready  sink accepts out_data
//   out_data   working/result register; meaningful only while out_valid=1
//   busy       high while rotating or holding a result
// -----------------------------------------------------------------------------
module rotate_right_restorer #(
  parameter int DW = 4,
  parameter int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] q;
  logic [AW-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            q   <= in_data;
            cnt <= in_amt;
          end
        end
        ROT: begin
          if (en) begin
            q   <= {q[0], q[DW-1:1]};
            cnt <= cnt - AW'(1);
          end
        end
        default: ; // DONE: q holds the result until and after the handshake
      endcase
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          // A zero amount needs no rotation; the word is already restored.
          state_next = (in_amt == '0) ? DONE : ROT;
        end
      end
      ROT: begin
        if (en && (cnt == AW'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs come only from registered state, so there is no combinational
  // path from any input to any output.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = q;

endmodule

// File: tb/tb_rotate_right_restorer.sv
// -----------------------------------------------------------------------------
// tb_rotate_right_restorer
//
// Directed bench for rotate_right_restorer (DW=4). Expected restored words are
// pushed to a scoreboard queue when a word is offered and popped when the
// block presents its output.
// -----------------------------------------------------------------------------
module tb_rotate_right_restorer;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int BUDGET = 20;

  logic          clk;
  logic          async_rst;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  logic [DW-1:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  rotate_right_restorer #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate right by a, taken from a doubled copy of the word.
  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] d, input int a);
    logic [2*DW-1:0] dd;
    dd = {d, d};
    return dd[a +: DW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; returns after the capture edge.
  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a);
    int w;
    w = 0;
    while (!in_ready && w < BUDGET) begin
      tick();
      w++;
    end
    check("send_in_ready", in_ready, 1'b1);
    in_data  = d;
    in_amt   = a;
    in_valid = 1'b1;
    sb.push_back(rotr(d, int'(a)));
    tick();
    in_valid = 1'b0;
    check("busy_after_capture", busy, 1'b1);
  endtask

  // Wait for out_valid (bounded), compare latency and data, then handshake.
  task automatic collect(input string tag, input int exp_lat);
    int cyc;
    logic [DW-1:0] exp;
    cyc = 0;
    while (!out_valid && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_out_valid"}, out_valid, 1'b1);
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    check({tag, "_out_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] en_q[5];
    logic [DW-1:0] held;
    logic [DW-1:0] rd;
    logic [AW-1:0] ra;

    async_rst = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    repeat (2) tick();

    check("rst_out_data", out_data, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    #2 async_rst = 1'b0;
    tick();

    // Stepwise restore of 1001 by 3, checking each intermediate q.
    send(4'b1001, 2'd3);
    check("t2_q0", out_data, 4'b1001);
    tick();
    check("t2_q1", out_data, 4'b1100);
    check("t2_nv1", out_valid, 1'b0);
    tick();
    check("t2_q2", out_data, 4'b0110);
    check("t2_nv2", out_valid, 1'b0);
    check("t2_in_ready_rot", in_ready, 1'b0);
    tick();
    check("t2_q3", out_data, 4'b0011);
    collect("t2", 0);

    // Round trip: 1011 left-rotated by 2 is 1110.
    send(4'b1110, 2'd2);
    collect("t3", 2);

    // Zero amount, with en low to show en is ignored outside rotation.
    en = 1'b0;
    send(4'b0110, 2'd0);
    check("t4_busy", busy, 1'b1);
    collect("t4", 0);
    en = 1'b1;

    // Enable pattern 1,0,0,1,1 on 0001 by 3.
    en_q[0] = 4'b1000; en_q[1] = 4'b1000; en_q[2] = 4'b1000;
    en_q[3] = 4'b0100; en_q[4] = 4'b0010;
    send(4'b0001, 2'd3);
    for (int i = 0; i < 5; i++) begin
      en = (i == 0 || i >= 3);
      tick();
      check($sformatf("t5_q%0d", i), out_data, en_q[i]);
      check($sformatf("t5_v%0d", i), out_valid, (i == 4));
    end
    en = 1'b1;
    collect("t5", 0);

    // Back-pressure in DONE with a competing input offer.
    send(4'b1110, 2'd2);
    tick();
    tick();
    held = out_data;
    check("t6_held", held, 4'b1011);
    in_data  = 4'b0110;
    in_amt   = 2'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_v%0d", i), out_valid, 1'b1);
      check($sformatf("t6_d%0d", i), out_data, held);
      check($sformatf("t6_ir%0d", i), in_ready, 1'b0);
    end
    void'(sb.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_hs_valid", out_valid, 1'b0);
    check("t6_hs_in_ready", in_ready, 1'b1);
    check("t6_hs_q_hold", out_data, held);
    sb.push_back(rotr(4'b0110, 1));
    tick();
    in_valid = 1'b0;
    check("t6_new_busy", busy, 1'b1);
    check("t6_new_q", out_data, 4'b0110);
    collect("t6_new", 1);

    // Random words.
    for (int i = 0; i < 4; i++) begin
      rd = DW'($urandom);
      ra = AW'($urandom_range(0, DW - 1));
      send(rd, ra);
      collect($sformatf("rnd%0d", i), int'(ra));
    end

    // Asynchronous reset in the middle of a rotation and mid-cycle.
    in_data  = 4'b1001;
    in_amt   = 2'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t1_pre_busy", busy, 1'b1);
    #2 async_rst = 1'b1;
    #1;
    check("t1_out_data", out_data, 4'b0000);
    check("t1_out_valid", out_valid, 1'b0);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_busy", busy, 1'b0);
    tick();
    #2 async_rst = 1'b0;
    tick();
    check("t1_after_out_valid", out_valid, 1'b0);

    // Recovery after reset.
    send(4'b0011, 2'd1);
    collect("post_rst", 1);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
